sky130_fd_io__amuxbus_arbiter: RTL and testbench
================================================

# sky130_fd_io__amuxbus_arbiter

Shares the two pad-ring analog mux buses (AMUXBUS_A, AMUXBUS_B) among up to NREQ pad-side requesters. Each bus has its own round-robin arbiter. Each arbiter drives one-hot switch enables to the pads with guaranteed break-before-make dead time and an analog settle window before the owner sees ready. It sits in the always-on VCCD core domain next to the IO ring and is the only block that drives the per-pad AMUX switch enables.

## Interface
- NREQ, 4, number of requesters per bus (2..16)
- DEAD_CYC, 4, cycles all switches on a bus stay open between owners (>=1)
- SETTLE_CYC, 8, cycles from switch enable to ready (>=1)
- CLK  input  1  block clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- BUS_OFF  input  1  force both buses open (power-down / brown-out)
- REQ_A  input  NREQ  per-requester request for AMUXBUS_A, level, held while in use
- REQ_B  input  NREQ  per-requester request for AMUXBUS_B
- EN_A  output  NREQ  one-hot-or-zero switch enable onto AMUXBUS_A, registered
- EN_B  output  NREQ  same for AMUXBUS_B
- RDY_A  output  NREQ  owner may use AMUXBUS_A (bus settled), registered, subset of EN_A
- RDY_B  output  NREQ  same for AMUXBUS_B
- BUSY_A  output  1  arbiter A not IDLE
- BUSY_B  output  1  arbiter B not IDLE

## Operation
- Two identical, independent arbiter instances (A, B). Nothing below couples them except BUS_OFF and RESET.
- Per-bus state: IDLE, SETTLE, OWNED, BREAK. Also an owner index, a round-robin pointer PTR, and a down-counter CNT of width clog2(max(DEAD_CYC,SETTLE_CYC)+1).
- Grant selection: scan from PTR upward with wrap at NREQ-1 to 0. The first set REQ bit wins. On a grant, PTR becomes winner+1 mod NREQ.
- IDLE: if any REQ and !BUS_OFF, grant the winner, set its EN bit, CNT=SETTLE_CYC-1, go to SETTLE.
- SETTLE: EN held. If the owner's REQ drops, clear EN, CNT=DEAD_CYC-1, go to BREAK. Otherwise, when CNT==0, set the owner's RDY and go to OWNED. Otherwise decrement CNT.
- OWNED: EN and RDY held while the owner's REQ is high. Other requests never preempt. When the owner's REQ drops, clear EN and RDY, CNT=DEAD_CYC-1, go to BREAK.
- BREAK: all EN/RDY low. Decrement CNT. When CNT==0 and !BUS_OFF: if any REQ, grant directly into SETTLE (same grant rule as IDLE); otherwise go to IDLE.
- BUS_OFF high in any state: EN/RDY cleared on that edge, CNT reloaded to DEAD_CYC-1 every cycle, state forced to BREAK. Dead time therefore counts from BUS_OFF deassertion.
- Invariants that must never be violated: EN is one-hot-or-zero. RDY implies EN of the same bit. No cycle has one EN bit falling and another rising on the same bus.
- Reset: all EN/RDY/BUSY = 0, both states IDLE, CNT=0, PTR=0 (requester 0 has highest priority first).

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Grant latency from IDLE: REQ sampled high at edge k gives EN high after edge k.
- Ready latency: EN rising at edge k gives RDY rising at edge k+SETTLE_CYC.
- Release: owner REQ sampled low at edge m gives EN/RDY low after edge m.
- Re-grant after release: a pending request gets its EN at edge m+DEAD_CYC, giving exactly DEAD_CYC open cycles. A request arriving later than that gets its EN one edge after it is sampled (via IDLE).
- Simultaneous release and new request in the same cycle: the new request is still subject to the full dead time.
- A request pulse shorter than one cycle between edges is not seen.
- A REQ drop during SETTLE aborts without RDY ever asserting.
- RESET asserted mid-operation: outputs go low on that edge regardless of state. RESET has priority over BUS_OFF, which has priority over REQ.

## Test plan
- Reset, then REQ_A=4'b0001 held: EN_A=0001 after the first sampling edge, RDY_A=0001 exactly 8 edges later, BUSY_A=1, and bus B stays all-zero.
- REQ_A=4'b0110 from IDLE, then requester 1 releases after ready: EN_A=0010 first. After release, EN_A=0000 for exactly 4 cycles, then EN_A=0100. PTR rotation verified.
- All four REQ_A held, each owner releasing after RDY: grants go 0,1,2,3,0. At no cycle is more than one EN_A bit set.
- Requester drops REQ_B 3 cycles into SETTLE: RDY_B never rises, EN_B falls on the sampling edge, and the 4-cycle BREAK follows.
- BUS_OFF pulsed for 10 cycles while both buses are OWNED: all EN/RDY go to 0 on the first edge. Re-grant occurs 4 edges after BUS_OFF falls, followed by the full 8-cycle settle.
- RESET asserted during OWNED on A and BREAK on B: all outputs 0 after that edge, and the next grant starts from requester 0 priority.

Source files
------------

// File: rtl/sky130_fd_io__amuxbus_arbiter.sv
// AMUXBUS_A / AMUXBUS_B switch-enable arbiter: one round-robin arbiter per bus with
// break-before-make dead time and an analog settle window before the owner sees ready.

module sky130_fd_io__amuxbus_arbiter_bus #(
    parameter int NREQ       = 4,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            bus_off,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] en,
    output logic [NREQ-1:0] rdy,
    output logic            busy
);
    localparam int MAX_CYC = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0]   CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [CW-1:0]   DEAD_LOAD   = CW'(DEAD_CYC - 1);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [NREQ-1:0] VEC_ZERO    = NREQ'(0);
    localparam logic [NREQ-1:0] VEC_ONE     = NREQ'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OWNED  = 2'd2;
    localparam logic [1:0] ST_BREAK  = 2'd3;

    logic [1:0]      state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    logic [NREQ-1:0] ptr_r, ptr_nxt_s;
    logic [NREQ-1:0] en_r, en_nxt_s;
    logic [NREQ-1:0] rdy_r, rdy_nxt_s;
    logic            busy_r;
    logic [NREQ-1:0] masked_s, win_s;
    logic            any_req_s, owner_req_s;

    function automatic logic [NREQ-1:0] lowest_one(input logic [NREQ-1:0] v);
        return v & (~v + VEC_ONE);
    endfunction

    // The pointer is kept one-hot, so the owner is simply the set bit of en_r.
    assign any_req_s   = |req;
    assign owner_req_s = |(req & en_r);

    // Round-robin pick: lowest request at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        masked_s = req & ~(ptr_r - VEC_ONE);
        if (masked_s != VEC_ZERO) begin
            win_s = lowest_one(masked_s);
        end else begin
            win_s = lowest_one(req);
        end
    end

    // Next-state logic; BUS_OFF overrides every state and keeps reloading the dead time.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ptr_nxt_s   = ptr_r;
        en_nxt_s    = en_r;
        rdy_nxt_s   = rdy_r;
        if (bus_off) begin
            state_nxt_s = ST_BREAK;
            cnt_nxt_s   = DEAD_LOAD;
            en_nxt_s    = VEC_ZERO;
            rdy_nxt_s   = VEC_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = SETTLE_LOAD;
                        en_nxt_s    = win_s;
                        rdy_nxt_s   = VEC_ZERO;
                        ptr_nxt_s   = {win_s[NREQ-2:0], win_s[NREQ-1]};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (!owner_req_s) begin
                        state_nxt_s = ST_BREAK;
                        cnt_nxt_s   = DEAD_LOAD;
                        en_nxt_s    = VEC_ZERO;
                        rdy_nxt_s   = VEC_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_nxt_s = ST_OWNED;
                        rdy_nxt_s   = en_r;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_OWNED: begin
                    if (!owner_req_s) begin
                        state_nxt_s = ST_BREAK;
                        cnt_nxt_s   = DEAD_LOAD;
                        en_nxt_s    = VEC_ZERO;
                        rdy_nxt_s   = VEC_ZERO;
                    end else begin
                        state_nxt_s = ST_OWNED;
                    end
                end
                ST_BREAK: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end else if (any_req_s) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = SETTLE_LOAD;
                        en_nxt_s    = win_s;
                        rdy_nxt_s   = VEC_ZERO;
                        ptr_nxt_s   = {win_s[NREQ-2:0], win_s[NREQ-1]};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    en_nxt_s    = VEC_ZERO;
                    rdy_nxt_s   = VEC_ZERO;
                end
            endcase
        end
    end

    // State and output registers; reset restores requester 0 as highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            ptr_r   <= VEC_ONE;
            en_r    <= VEC_ZERO;
            rdy_r   <= VEC_ZERO;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            en_r    <= en_nxt_s;
            rdy_r   <= rdy_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign en   = en_r;
    assign rdy  = rdy_r;
    assign busy = busy_r;
endmodule

module sky130_fd_io__amuxbus_arbiter #(
    parameter int NREQ       = 4,
    parameter int DEAD_CYC   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            BUS_OFF,
    input  logic [NREQ-1:0] REQ_A,
    input  logic [NREQ-1:0] REQ_B,
    output logic [NREQ-1:0] EN_A,
    output logic [NREQ-1:0] EN_B,
    output logic [NREQ-1:0] RDY_A,
    output logic [NREQ-1:0] RDY_B,
    output logic            BUSY_A,
    output logic            BUSY_B
);
    sky130_fd_io__amuxbus_arbiter_bus #(
        .NREQ      (NREQ),
        .DEAD_CYC  (DEAD_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) u_bus_a (
        .clk    (CLK),
        .reset  (RESET),
        .bus_off(BUS_OFF),
        .req    (REQ_A),
        .en     (EN_A),
        .rdy    (RDY_A),
        .busy   (BUSY_A)
    );

    sky130_fd_io__amuxbus_arbiter_bus #(
        .NREQ      (NREQ),
        .DEAD_CYC  (DEAD_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) u_bus_b (
        .clk    (CLK),
        .reset  (RESET),
        .bus_off(BUS_OFF),
        .req    (REQ_B),
        .en     (EN_B),
        .rdy    (RDY_B),
        .busy   (BUSY_B)
    );
endmodule

// File: tb/tb_sky130_fd_io__amuxbus_arbiter.sv
// Bench for the AMUXBUS arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against an integer-level owner/timer model of both buses.

module tb_sky130_fd_io__amuxbus_arbiter;
    localparam int NREQ   = 4;
    localparam int DEAD   = 4;
    localparam int SETTLE = 8;

    logic            clk;
    logic            reset;
    logic            bus_off;
    logic [NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0] en_a, en_b, rdy_a, rdy_b;
    logic            busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner index (-1 = none), edges since grant, dead edges still to wait, next start index.
    int m_owner[2];
    int m_age[2];
    int m_wait[2];
    int m_ptr[2];

    sky130_fd_io__amuxbus_arbiter #(
        .NREQ      (NREQ),
        .DEAD_CYC  (DEAD),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .CLK    (clk),
        .RESET  (reset),
        .BUS_OFF(bus_off),
        .REQ_A  (req_a),
        .REQ_B  (req_b),
        .EN_A   (en_a),
        .EN_B   (en_b),
        .RDY_A  (rdy_a),
        .RDY_B  (rdy_b),
        .BUSY_A (busy_a),
        .BUSY_B (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_owner[b] = -1;
            m_age[b]   = 0;
            m_wait[b]  = 0;
            m_ptr[b]   = 0;
        end
    endtask

    task automatic model_grant(input int b, input logic [NREQ-1:0] req);
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (m_ptr[b] + i) % NREQ;
            if (req[idx]) begin
                m_owner[b] = idx;
                m_age[b]   = 0;
                m_ptr[b]   = (idx + 1) % NREQ;
                return;
            end
        end
    endtask

    task automatic model_bus(input int b, input logic [NREQ-1:0] req, input logic off);
        if (off) begin
            m_owner[b] = -1;
            m_wait[b]  = DEAD;
        end else if (m_owner[b] >= 0) begin
            if (!req[m_owner[b]]) begin
                m_owner[b] = -1;
                m_wait[b]  = DEAD;
            end else begin
                m_age[b]++;
            end
        end else if (m_wait[b] > 0) begin
            m_wait[b]--;
            if (m_wait[b] == 0 && req != '0) model_grant(b, req);
        end else if (req != '0) begin
            model_grant(b, req);
        end
    endtask

    function automatic logic [NREQ-1:0] m_en(input int b);
        logic [NREQ-1:0] one;
        one = NREQ'(1);
        if (m_owner[b] < 0) return '0;
        return one << m_owner[b];
    endfunction

    function automatic logic [NREQ-1:0] m_rdy(input int b);
        if (m_owner[b] >= 0 && m_age[b] >= SETTLE) return m_en(b);
        return '0;
    endfunction

    function automatic logic m_busy(input int b);
        return (m_owner[b] >= 0) || (m_wait[b] > 0);
    endfunction

    // One clock: model follows the sampled inputs, outputs compared on the falling edge.
    task automatic cycle();
        logic [NREQ-1:0] prev_a, prev_b;
        prev_a = en_a;
        prev_b = en_b;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            model_bus(0, req_a, bus_off);
            model_bus(1, req_b, bus_off);
        end
        @(negedge clk);
        chk("en_a", 32'(en_a), 32'(m_en(0)));
        chk("rdy_a", 32'(rdy_a), 32'(m_rdy(0)));
        chk("busy_a", 32'(busy_a), 32'(m_busy(0)));
        chk("en_b", 32'(en_b), 32'(m_en(1)));
        chk("rdy_b", 32'(rdy_b), 32'(m_rdy(1)));
        chk("busy_b", 32'(busy_b), 32'(m_busy(1)));
        chk("onehot_a", 32'($countones(en_a) <= 1), 32'd1);
        chk("onehot_b", 32'($countones(en_b) <= 1), 32'd1);
        chk("rdy_sub_en_a", 32'((rdy_a & ~en_a) == '0), 32'd1);
        chk("rdy_sub_en_b", 32'((rdy_b & ~en_b) == '0), 32'd1);
        if (!$isunknown(prev_a) && !$isunknown(prev_b)) begin
            chk("bbm_a", 32'(((prev_a & ~en_a) != '0) && ((en_a & ~prev_a) != '0)), 32'd0);
            chk("bbm_b", 32'(((prev_b & ~en_b) != '0) && ((en_b & ~prev_b) != '0)), 32'd0);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_rdy_a(input int budget);
        int n;
        n = 0;
        while (rdy_a == '0 && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_rdy_a", 32'(rdy_a != '0), 32'd1);
    endtask

    initial begin
        logic [NREQ-1:0] exp_oh;
        model_reset();
        reset   = 1'b1;
        bus_off = 1'b0;
        req_a   = 4'b0000;
        req_b   = 4'b0000;
        run(2);
        chk("reset_en_a", 32'(en_a), 32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_en_b", 32'(en_b), 32'd0);
        reset = 1'b0;

        // Grant and settle latency from IDLE.
        req_a = 4'b0001;
        cycle();
        chk("t1_en_a", 32'(en_a), 32'd1);
        chk("t1_busy_a", 32'(busy_a), 32'd1);
        run(SETTLE - 1);
        chk("t1_rdy_early", 32'(rdy_a), 32'd0);
        cycle();
        chk("t1_rdy_a", 32'(rdy_a), 32'd1);
        chk("t1_en_b", 32'(en_b), 32'd0);
        chk("t1_busy_b", 32'(busy_b), 32'd0);

        // Release, idle, then two-way request with exact dead time and pointer rotation.
        req_a = 4'b0000;
        run(DEAD + 2);
        chk("t2_idle", 32'(busy_a), 32'd0);
        req_a = 4'b0110;
        cycle();
        chk("t2_first", 32'(en_a), 32'h2);
        run(SETTLE);
        chk("t2_rdy", 32'(rdy_a), 32'h2);
        req_a = 4'b0100;
        for (int i = 0; i < DEAD; i++) begin
            cycle();
            chk("t2_open", 32'(en_a), 32'd0);
        end
        cycle();
        chk("t2_regrant", 32'(en_a), 32'h4);
        req_a = 4'b0111;
        run(SETTLE);
        req_a = 4'b0011;
        run(DEAD + 1);
        chk("t2_ptr", 32'(en_a), 32'h1);

        // All four held on A: strict round-robin order 0,1,2,3,0.
        reset = 1'b1;
        req_a = 4'b0000;
        cycle();
        reset = 1'b0;
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_rdy_a(40);
            exp_oh = 4'b0001 << (g % NREQ);
            chk("t3_order", 32'(en_a), 32'(exp_oh));
            req_a = 4'b1111 & ~en_a;
            cycle();
            chk("t3_release", 32'(en_a), 32'd0);
            req_a = 4'b1111;
        end
        req_a = 4'b0000;

        // Abort during SETTLE on B, with a new request arriving on the release edge.
        req_b = 4'b0001;
        cycle();
        chk("t4_en_b", 32'(en_b), 32'h1);
        run(2);
        req_b = 4'b0010;
        cycle();
        chk("t4_drop_en", 32'(en_b), 32'd0);
        chk("t4_drop_rdy", 32'(rdy_b), 32'd0);
        for (int i = 0; i < DEAD - 1; i++) begin
            cycle();
            chk("t4_open", 32'(en_b), 32'd0);
        end
        cycle();
        chk("t4_regrant", 32'(en_b), 32'h2);

        // BUS_OFF while both buses are owned.
        reset = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        cycle();
        reset = 1'b0;
        req_a = 4'b0001;
        req_b = 4'b0010;
        run(SETTLE + 2);
        chk("t5_own_a", 32'(rdy_a), 32'h1);
        chk("t5_own_b", 32'(rdy_b), 32'h2);
        bus_off = 1'b1;
        cycle();
        chk("t5_off_en_a", 32'(en_a), 32'd0);
        chk("t5_off_en_b", 32'(en_b), 32'd0);
        chk("t5_off_rdy_a", 32'(rdy_a), 32'd0);
        run(9);
        bus_off = 1'b0;
        for (int i = 0; i < DEAD - 1; i++) begin
            cycle();
            chk("t5_dead", 32'(en_a), 32'd0);
        end
        cycle();
        chk("t5_regrant_a", 32'(en_a), 32'h1);
        chk("t5_regrant_b", 32'(en_b), 32'h2);
        run(SETTLE - 1);
        chk("t5_rdy_early", 32'(rdy_a), 32'd0);
        cycle();
        chk("t5_rdy_a", 32'(rdy_a), 32'h1);

        // RESET with A owned and B in BREAK; priority restarts at requester 0.
        req_b = 4'b0000;
        cycle();
        chk("t6_b_break", 32'(busy_b), 32'd1);
        reset = 1'b1;
        req_a = 4'b1001;
        req_b = 4'b1001;
        cycle();
        chk("t6_rst_en_a", 32'(en_a), 32'd0);
        chk("t6_rst_rdy_a", 32'(rdy_a), 32'd0);
        chk("t6_rst_busy_b", 32'(busy_b), 32'd0);
        reset = 1'b0;
        cycle();
        chk("t6_prio_a", 32'(en_a), 32'h1);
        chk("t6_prio_b", 32'(en_b), 32'h1);

        // Random traffic with occasional BUS_OFF bursts and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 15) == 0) req_a[b] = ~req_a[b];
                if ($urandom_range(0, 15) == 0) req_b[b] = ~req_b[b];
            end
            if (bus_off) bus_off = ($urandom_range(0, 3) != 0);
            else         bus_off = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
